// File: rtl/player_health.sv
// Per-player lives, invulnerability and round-timer controller on the 1 Hz tick.
// Async active-high true_reset; clock clock_1Hz.
// Ports:
//   in:  clock_1Hz, true_reset, start, hitP1, hitP2
//   out: livesP1/P2 [1:0], invulnP1/P2, round_time [7:0],
//        state [1:0] (0 IDLE,1 PLAY,2 SUDDEN,3 OVER),
//        winner [1:0] (01 P1, 10 P2, 11 draw), game_over
// Params: LIVES (1..3), INVULN_SEC (1..7), ROUND_SEC (1..255).
// Option macro HEALTH_SUDDEN_DEATH_EN: timer expiry enters SUDDEN
// instead of ending the round on a lives comparison.
module player_health #(
  parameter int LIVES      = 3,
  parameter int INVULN_SEC = 2,
  parameter int ROUND_SEC  = 120
) (
  input  logic       clock_1Hz,
  input  logic       true_reset,
  input  logic       start,
  input  logic       hitP1,
  input  logic       hitP2,
  output logic [1:0] livesP1,
  output logic [1:0] livesP2,
  output logic       invulnP1,
  output logic       invulnP2,
  output logic [7:0] round_time,
  output logic [1:0] state,
  output logic [1:0] winner,
  output logic       game_over
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    SUDDEN = 2'd2,
    OVER   = 2'd3
  } state_t;

  localparam logic [1:0] L0   = 2'(LIVES);
  localparam logic [2:0] INV0 = 3'(INVULN_SEC);
  localparam logic [7:0] RT0  = 8'(ROUND_SEC);

  state_t     st, st_n;
  logic [1:0] l1, l2, l1_n, l2_n;
  logic [2:0] i1, i2, i1_n, i2_n;
  logic [7:0] rt, rt_n;
  logic [1:0] win, win_n;
  logic       go, go_n;

  always_comb begin
    st_n  = st;
    l1_n  = l1;
    l2_n  = l2;
    i1_n  = i1;
    i2_n  = i2;
    rt_n  = rt;
    win_n = win;
    go_n  = go;
    unique case (st)
      IDLE: begin
        if (start) st_n = PLAY;
      end
      PLAY: begin
        i1_n = (i1 != 3'd0) ? i1 - 3'd1 : 3'd0;
        i2_n = (i2 != 3'd0) ? i2 - 3'd1 : 3'd0;
        rt_n = (rt != 8'd0) ? rt - 8'd1 : 8'd0;
        // a hit during invulnerability is dropped, never queued
        if (hitP1 && i1 == 3'd0 && l1 != 2'd0) begin
          l1_n = l1 - 2'd1;
          i1_n = INV0;
        end
        if (hitP2 && i2 == 3'd0 && l2 != 2'd0) begin
          l2_n = l2 - 2'd1;
          i2_n = INV0;
        end
        // a fatal hit outranks timer expiry on the same edge
        if (l1_n == 2'd0 || l2_n == 2'd0) begin
          st_n  = OVER;
          go_n  = 1'b1;
          win_n = {l1_n == 2'd0, l2_n == 2'd0};
        end else if (rt_n == 8'd0) begin
`ifdef HEALTH_SUDDEN_DEATH_EN
          st_n = SUDDEN;
`else
          st_n = OVER;
          go_n = 1'b1;
          if (l1_n > l2_n)      win_n = 2'b01;
          else if (l2_n > l1_n) win_n = 2'b10;
          else                  win_n = 2'b11;
`endif
        end
      end
`ifdef HEALTH_SUDDEN_DEATH_EN
      SUDDEN: begin
        i1_n = (i1 != 3'd0) ? i1 - 3'd1 : 3'd0;
        i2_n = (i2 != 3'd0) ? i2 - 3'd1 : 3'd0;
        if (hitP1) l1_n = 2'd0;
        if (hitP2) l2_n = 2'd0;
        if (hitP1 || hitP2) begin
          st_n  = OVER;
          go_n  = 1'b1;
          win_n = {hitP1, hitP2};
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock_1Hz or posedge true_reset) begin
    if (true_reset) begin
      st  <= IDLE;
      l1  <= L0;
      l2  <= L0;
      i1  <= 3'd0;
      i2  <= 3'd0;
      rt  <= RT0;
      win <= 2'b00;
      go  <= 1'b0;
    end else begin
      st  <= st_n;
      l1  <= l1_n;
      l2  <= l2_n;
      i1  <= i1_n;
      i2  <= i2_n;
      rt  <= rt_n;
      win <= win_n;
      go  <= go_n;
    end
  end

  assign livesP1    = l1;
  assign livesP2    = l2;
  assign invulnP1   = (i1 != 3'd0);
  assign invulnP2   = (i2 != 3'd0);
  assign round_time = rt;
  assign state      = st;
  assign winner     = win;
  assign game_over  = go;

endmodule

// File: tb/tb_player_health.sv
// Directed bench for player_health: a default-round instance and a
// short-round (ROUND_SEC=3) instance share one 1 Hz tick.
module tb_player_health;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, start_a, h1_a, h2_a;
  logic [1:0] l1_a, l2_a, st_a, win_a;
  logic       iv1_a, iv2_a, go_a;
  logic [7:0] rt_a;

  logic       rst_b, start_b, h1_b, h2_b;
  logic [1:0] l1_b, l2_b, st_b, win_b;
  logic       iv1_b, iv2_b, go_b;
  logic [7:0] rt_b;

  player_health u_a (
    .clock_1Hz (clk),
    .true_reset(rst_a),
    .start     (start_a),
    .hitP1     (h1_a),
    .hitP2     (h2_a),
    .livesP1   (l1_a),
    .livesP2   (l2_a),
    .invulnP1  (iv1_a),
    .invulnP2  (iv2_a),
    .round_time(rt_a),
    .state     (st_a),
    .winner    (win_a),
    .game_over (go_a)
  );

  player_health #(.ROUND_SEC(3)) u_b (
    .clock_1Hz (clk),
    .true_reset(rst_b),
    .start     (start_b),
    .hitP1     (h1_b),
    .hitP2     (h2_b),
    .livesP1   (l1_b),
    .livesP2   (l2_b),
    .invulnP1  (iv1_b),
    .invulnP2  (iv2_b),
    .round_time(rt_b),
    .state     (st_b),
    .winner    (win_b),
    .game_over (go_b)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_a_reset(input string p);
    chk({p, " state"}, st_a, 0);
    chk({p, " l1"}, l1_a, 3);
    chk({p, " l2"}, l2_a, 3);
    chk({p, " iv1"}, iv1_a, 0);
    chk({p, " iv2"}, iv2_a, 0);
    chk({p, " rt"}, rt_a, 120);
    chk({p, " win"}, win_a, 0);
    chk({p, " go"}, go_a, 0);
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b0; h1_a = 1'b0; h2_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; h1_b = 1'b0; h2_b = 1'b0;
    #3;
    chk_a_reset("rst");
    rst_a = 1'b0;
    start_a = 1'b1;
    tick(1);
    chk("start state", st_a, 1);
    chk("start rt", rt_a, 120);
    start_a = 1'b0;
    tick(5);
    chk("run5 state", st_a, 1);
    chk("run5 rt", rt_a, 115);
    chk("run5 l1", l1_a, 3);
    chk("run5 l2", l2_a, 3);
    chk("run5 win", win_a, 0);

    h1_a = 1'b1;
    tick(1);
    chk("hit1 l1", l1_a, 2);
    chk("hit1 iv1", iv1_a, 1);
    chk("hit1 l2", l2_a, 3);
    tick(1);
    chk("hit2 l1", l1_a, 2);
    chk("hit2 iv1", iv1_a, 1);
    tick(1);
    chk("hit3 l1", l1_a, 2);
    chk("hit3 iv1", iv1_a, 0);
    tick(1);
    chk("hit4 l1", l1_a, 1);
    chk("hit4 iv1", iv1_a, 1);
    chk("hit4 rt", rt_a, 111);
    h1_a = 1'b0;

    #2 rst_a = 1'b1;
    #1;
    chk_a_reset("async");
    #1 rst_a = 1'b0;

    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    h1_a = 1'b1;
    h2_a = 1'b1;
    tick(6);
    chk("both l1", l1_a, 1);
    chk("both l2", l2_a, 1);
    chk("both state", st_a, 1);
    tick(1);
    chk("dead l1", l1_a, 0);
    chk("dead l2", l2_a, 0);
    chk("dead state", st_a, 3);
    chk("dead win", win_a, 3);
    chk("dead go", go_a, 1);
    start_a = 1'b1;
    tick(2);
    chk("hold state", st_a, 3);
    chk("hold rt", rt_a, 113);
    chk("hold win", win_a, 3);
    start_a = 1'b0;
    h1_a = 1'b0;
    h2_a = 1'b0;

    rst_b = 1'b0;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    chk("b start rt", rt_b, 3);
    tick(1);
    chk("b rt2", rt_b, 2);
    tick(1);
    chk("b rt1", rt_b, 1);
    tick(1);
    chk("b rt0", rt_b, 0);
`ifdef HEALTH_SUDDEN_DEATH_EN
    chk("b sudden state", st_b, 2);
    chk("b sudden win", win_b, 0);
    tick(1);
    chk("b sudden hold", st_b, 2);
    chk("b sudden rt", rt_b, 0);
    h2_b = 1'b1;
    tick(1);
    h2_b = 1'b0;
    chk("b sd state", st_b, 3);
    chk("b sd win", win_b, 1);
    chk("b sd l2", l2_b, 0);
    chk("b sd l1", l1_b, 3);
    chk("b sd go", go_b, 1);
`else
    chk("b over state", st_b, 3);
    chk("b over win", win_b, 3);
    chk("b over go", go_b, 1);
    h2_b = 1'b1;
    tick(1);
    h2_b = 1'b0;
    chk("b over l2", l2_b, 3);
    chk("b over rt", rt_b, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
